// File: rtl/reg16_wr_arbiter.sv
// Round-robin write arbiter sharing the parallel-load port of one reg16.
// Optional burst lock enabled by defining REG16_ARB_LOCK_EN (adds the Lock port).
module reg16_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   Req,
    input  logic [N_REQ*W-1:0] ReqData,
`ifdef REG16_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   Lock,
`endif
    output logic [N_REQ-1:0]   Grant,
    output logic [N_REQ-1:0]   Done,
    output logic               LD_REG,
    output logic [W-1:0]       dIn,
    output logic [15:0]        WrCount
);

    localparam int GW = $clog2(N_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [GW-1:0]    g, g_nxt;
    logic [GW-1:0]    ptr, ptr_nxt;
    logic [GW-1:0]    pick;
    logic             found;
    logic             burst;
    logic [N_REQ-1:0] gsel;
    int               idx;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Burst continuation: granted requester keeps the port while locked.
`ifdef REG16_ARB_LOCK_EN
    always_comb begin
        burst = Lock[g] & Req[g];
    end
`else
    always_comb begin
        burst = 1'b0;
    end
`endif

    // Next-state, winner and pointer update.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    g_nxt     = pick;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = ACK;
            end
            ACK: begin
                if (burst) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = (g == GW'(N_REQ - 1)) ? '0 : g + GW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, winner, pointer and completed-load counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            g       <= '0;
            ptr     <= '0;
            WrCount <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
            if (state == LOAD) begin
                WrCount <= WrCount + 16'd1;
            end
        end
    end

    // Output decodes from registered state only.
    always_comb begin
        gsel   = {{(N_REQ-1){1'b0}}, 1'b1} << g;
        LD_REG = (state == LOAD);
        Grant  = (state == LOAD || state == ACK) ? gsel : '0;
        Done   = (state == ACK) ? gsel : '0;
        dIn    = LD_REG ? ReqData[int'(g)*W +: W] : '0;
    end

endmodule
